// File: rtl/t_ff_bank_pkg.sv
// Shared opcodes and FSM state encoding for the toggle flip-flop bank controller.
package t_ff_bank_pkg;

  localparam int unsigned OP_W = 2;

  localparam logic [OP_W-1:0] OP_CLEAR = 2'b00;
  localparam logic [OP_W-1:0] OP_LOAD  = 2'b01;
  localparam logic [OP_W-1:0] OP_UP    = 2'b10;
  localparam logic [OP_W-1:0] OP_DOWN  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/t_cell.sv
// Single toggle flip-flop: flips on T, holds otherwise, clears on async reset.
module t_cell (
  input  logic Clk,
  input  logic Rst_n,
  input  logic T,
  output logic Q
);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Q <= 1'b0;
    end else if (T) begin
      Q <= ~Q;
    end
  end

endmodule

// File: rtl/t_ff_bank_ctrl.sv
// Command sequencer steering a bank of toggle flip-flops to clear, load or count
// by generating the per-bit toggle mask each cycle.
module t_ff_bank_ctrl
  import t_ff_bank_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned STEP_W = 8
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [WIDTH-1:0]  cmd_data,
  input  logic [STEP_W-1:0] cmd_steps,
  output logic [WIDTH-1:0]  Q,
  output logic              busy,
  output logic              done,
  output logic              wrap
);

  state_t            state_q, state_d;
  logic [OP_W-1:0]   op_q;
  logic [WIDTH-1:0]  data_q;
  logic [STEP_W-1:0] steps_q;
  logic [WIDTH-1:0]  t_mask;
  logic [WIDTH-1:0]  up_mask, dn_mask;
  logic              accept;
  logic              is_count;

  assign cmd_ready = (state_q == ST_IDLE) & Rst_n;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign accept    = cmd_valid & cmd_ready;
  assign is_count  = op_q[1];

  // Ripple-free count masks: bit i toggles when all lower bits are 1 (up) or 0 (down).
  always_comb begin
    logic [WIDTH-1:0] low;
    low        = '0;
    up_mask    = '0;
    dn_mask    = '0;
    up_mask[0] = 1'b1;
    dn_mask[0] = 1'b1;
    for (int unsigned i = 1; i < WIDTH; i++) begin
      low[i-1]   = 1'b1;
      up_mask[i] = ((Q & low) == low);
      dn_mask[i] = ((Q & low) == '0);
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    t_mask  = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (cmd_op[1] && (cmd_steps == '0)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        case (op_q)
          OP_CLEAR: t_mask = Q;
          OP_LOAD:  t_mask = Q ^ data_q;
          OP_UP:    t_mask = up_mask;
          default:  t_mask = dn_mask;
        endcase
        if (!is_count || (steps_q == STEP_W'(1))) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Command capture, step countdown and the registered wrap pulse.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      op_q    <= OP_CLEAR;
      data_q  <= '0;
      steps_q <= '0;
      wrap    <= 1'b0;
    end else begin
      if (accept) begin
        op_q    <= cmd_op;
        data_q  <= cmd_data;
        steps_q <= cmd_steps;
      end else if ((state_q == ST_EXEC) && is_count) begin
        steps_q <= steps_q - STEP_W'(1);
      end
      wrap <= (state_q == ST_EXEC) &&
              (((op_q == OP_UP)   && (Q == '1)) ||
               ((op_q == OP_DOWN) && (Q == '0)));
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_bank
    t_cell u_cell (
      .Clk   (Clk),
      .Rst_n (Rst_n),
      .T     (t_mask[g]),
      .Q     (Q[g])
    );
  end

endmodule

// File: doc/t_ff_bank_ctrl.md
Name: t_ff_bank_ctrl

Overview:
- Command-driven sequencer for a bank of WIDTH toggle flip-flops. The bank is the only state element that holds the count value.
- Each cycle it computes the per-bit toggle mask T that steers the bank to one of these results:
  - cleared
  - loaded with a target value
  - stepped up or down a programmed number of counts
- Sits between a command source (valid/ready handshake) and any logic consuming the registered count value Q.

Parameters:
- WIDTH, 4, number of toggle flip-flops in the bank (>=2).
- STEP_W, 8, width of the step-count field.

Ports:
- Clk  in  1  rising-edge clock.
- Rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  2  opcode: 00 CLEAR, 01 LOAD, 10 COUNT_UP, 11 COUNT_DOWN.
- cmd_data  in  WIDTH  LOAD target value; ignored for other ops.
- cmd_steps  in  STEP_W  number of counts for COUNT_UP/DOWN; ignored for other ops.
- Q  out  WIDTH  bank state.
- busy  out  1  command in progress (EXEC or DONE).
- done  out  1  one-cycle completion pulse.
- wrap  out  1  one-cycle pulse following a wrap-around edge.

Behaviour:
- Clock and reset: one clock, Clk. Reset is asynchronous and active-low on Rst_n.
- Reset values (immediate on Rst_n low): Q=0, state=IDLE, done=0, wrap=0, busy=0. cmd_ready=0 while Rst_n is low.
- FSM states: IDLE, EXEC, DONE. All decisions below are on the rising edge of Clk.
- cmd_ready = (state==IDLE) & Rst_n. busy = (state!=IDLE).
- Accept condition: cmd_valid & cmd_ready at edge k. At that edge, latch op, data and a step counter (steps).
  - If steps==0 and op is COUNT_*: go directly to DONE.
  - Otherwise: go to EXEC.
- T mask is valid only in EXEC; T=0 in all other states, so the bank holds.
  - CLEAR: T = Q.
  - LOAD: T = Q ^ data.
  - COUNT_UP: T[0]=1; T[i] = &Q[i-1:0].
  - COUNT_DOWN: T[0]=1; T[i] = &~Q[i-1:0].
- EXEC length:
  - CLEAR and LOAD: exactly one cycle.
  - COUNT_*: the step counter decrements each EXEC cycle. The FSM leaves EXEC on the edge where the counter equals 1, then enters DONE.
- Latency:
  - LOAD/CLEAR accepted at edge k: Q updates at edge k+1; done is high from k+1 to k+2; cmd_ready returns at edge k+2.
  - COUNT with n steps: Q updates at edges k+1..k+n; done is high from k+n to k+n+1.
  - COUNT with n=0: done is high from k to k+1; Q is unchanged.
- DONE lasts exactly one cycle and asserts done. cmd_ready=0 during DONE, then the FSM returns to IDLE.
- Arithmetic is modulo 2^WIDTH. cmd_steps may exceed 2^WIDTH; multiple wraps are allowed.
- wrap is a registered pulse, high for the cycle after any COUNT edge where Q goes all-ones→0 (up) or 0→all-ones (down).
  - wrap is never asserted for CLEAR or LOAD.
  - wrap and done may be high in the same cycle.
- cmd_valid while busy: ignored, not queued. The upstream source must hold cmd_valid until it sees cmd_ready.
- Reset mid-operation: immediate return to reset values. The command is abandoned and done is not asserted.

Decomposition:
- Package t_ff_bank_pkg holds:
  - opcode localparams OP_CLEAR/OP_LOAD/OP_UP/OP_DOWN;
  - state encoding ST_IDLE/ST_EXEC/ST_DONE.
- Sub-module t_cell: one toggle flip-flop.
  - Ports: Clk, Rst_n (async active-low, clears to 0), T, Q.
  - On each rising edge: Q toggles when T=1 and holds when T=0.
  - The controller instantiates WIDTH copies of t_cell via generate. Controller logic is only FSM, step counter, mask generation and pulses.

Test Plan:
1. Reset, then LOAD data=4'hA at edge k → Q=4'hA after edge k+1; done pulses for exactly one cycle; cmd_ready=0 for two cycles, then 1.
2. LOAD 4'hE, then COUNT_UP steps=3 → Q sequence F, 0, 1 on consecutive edges; wrap high for the single cycle after the F→0 edge; done after the third edge; final Q=1.
3. CLEAR, then COUNT_DOWN steps=2 → Q sequence F, E; wrap pulses once after the 0→F edge; final Q=E.
4. COUNT_UP steps=0 from Q=5 → done pulses on the cycle after acceptance; Q stays 5; no wrap.
5. COUNT_UP steps=20 from Q=0, assert Rst_n=0 after 7 edges → Q=0, busy=0 and done=0 immediately and asynchronously. After release, a LOAD 4'h3 completes normally.
6. While COUNT_UP steps=4 is executing, drive cmd_valid with LOAD 4'h9 → LOAD not accepted until cmd_ready=1. The count completes with Q=start+4. The LOAD is then accepted and gives Q=9.
